// File: rtl/btn_deb_rpt.sv
// btn_deb_rpt: multi-channel button debouncer with press/release strobes, long-press flag and auto-repeat
module btn_deb_rpt #(
  parameter int N       = 4,
  parameter int DEB     = 8,
  parameter int RPT_DLY = 500,
  parameter int RPT_PER = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [N-1:0] btn,
  input  logic [N-1:0] rpt_en,
  output logic [N-1:0] st,
  output logic [N-1:0] rel,
  output logic [N-1:0] lvl,
  output logic [N-1:0] long
);
  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;
  logic [N-1:0] s1, s;
  always_ff @(posedge clk) begin
    s1 <= rst_n ? btn : '0;
    s  <= rst_n ? s1 : '0;
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t     state, state_nx;
    logic [7:0] dc;
    logic [9:0] rc, rc_nx;
    logic       lvl_q, long_q, st_q, rel_q;
    logic       long_nx, st_nx, rel_nx;
    logic       diff, flip, rise, fall, dly_hit, per_hit;
    assign diff    = s[i] ^ lvl_q;
    assign flip    = ce && diff && dc == 8'(DEB - 1);
    assign rise    = flip && !lvl_q;
    assign fall    = flip && lvl_q;
    assign dly_hit = rc == 10'(RPT_DLY - 1);
    assign per_hit = rc == 10'(RPT_PER - 1);
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state  <= IDLE;
        dc     <= '0;
        rc     <= '0;
        lvl_q  <= 1'b0;
        long_q <= 1'b0;
        st_q   <= 1'b0;
        rel_q  <= 1'b0;
      end else begin
        state  <= state_nx;
        dc     <= !ce ? dc : (!diff || flip) ? '0 : dc + 8'd1;
        rc     <= rc_nx;
        lvl_q  <= lvl_q ^ flip;
        long_q <= long_nx;
        st_q   <= st_nx;
        rel_q  <= rel_nx;
      end
    end
    // a release on the same tick as a delay/period expiry takes priority
    always_comb begin
      state_nx = state;
      rc_nx    = rc;
      long_nx  = long_q;
      if (fall) begin
        state_nx = IDLE;
        rc_nx    = '0;
        long_nx  = 1'b0;
      end else if (rise) begin
        state_nx = HELD;
        rc_nx    = '0;
      end else if (ce && state == HELD && (long_q || dly_hit)) begin
        state_nx = rpt_en[i] ? RPT : HELD;
        rc_nx    = '0;
        long_nx  = 1'b1;
      end else if (ce && state == HELD) begin
        rc_nx = rc + 10'd1;
      end else if (ce && state == RPT) begin
        rc_nx = per_hit ? '0 : rc + 10'd1;
      end
    end
    always_comb begin
      st_nx  = rise || (ce && !fall && rpt_en[i] &&
               ((state == HELD && !long_q && dly_hit) || (state == RPT && per_hit)));
      rel_nx = fall;
    end
    assign lvl[i]  = lvl_q;
    assign long[i] = long_q;
    assign st[i]   = st_q;
    assign rel[i]  = rel_q;
  end
endmodule

// File: tb/tb_btn_deb_rpt.sv
// tb_btn_deb_rpt: directed checks of debounce, strobes, long-press, auto-repeat and reset behaviour
module tb_btn_deb_rpt;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic [N-1:0] btn = '0, rpt_en = '0;
  logic [N-1:0] st, rel, lvl, long;
  logic [N-1:0] st_s, rel_s;
  int errors = 0, checks = 0, tn = 0, ch = 0, idle_bad = 0, both_bad = 0;
  int stq[$], relq[$];

  btn_deb_rpt #(.N(N), .DEB(8), .RPT_DLY(500), .RPT_PER(100)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .btn(btn), .rpt_en(rpt_en),
    .st(st), .rel(rel), .lvl(lvl), .long(long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    repeat (3) begin
      @(negedge clk);
      if ((st | rel) !== '0) idle_bad++;
    end
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    tn++;
    st_s = st;
    rel_s = rel;
    if ((st & rel) !== '0) both_bad++;
    if (st[ch]) stq.push_back(tn);
    if (rel[ch]) relq.push_back(tn);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr(input int c);
    ch = c;
    stq.delete();
    relq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    btn = '1;
    repeat (4) @(negedge clk);
    checks++; if (st !== '0) begin errors++; $display("FAIL reset_st: got %0h expected 0", st); end
    checks++; if (rel !== '0) begin errors++; $display("FAIL reset_rel: got %0h expected 0", rel); end
    checks++; if (lvl !== '0) begin errors++; $display("FAIL reset_lvl: got %0h expected 0", lvl); end
    checks++; if (long !== '0) begin errors++; $display("FAIL reset_long: got %0h expected 0", long); end
    ce = 1'b0;
    btn = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_press();
    int t0;
    clr(0);
    btn[0] = 1'b1;
    t0 = tn;
    run(7);
    checks++; if (lvl[0] !== 1'b0) begin errors++; $display("FAIL press_early: lvl0 got %0b expected 0", lvl[0]); end
    run(1);
    checks++; if (st_s[0] !== 1'b1 || lvl[0] !== 1'b1) begin errors++; $display("FAIL press_st: st0=%0b lvl0=%0b expected 1 1", st_s[0], lvl[0]); end
    run(4);
    checks++; if (stq.size() != 1 || stq[0] != t0 + 8) begin errors++; $display("FAIL press_once: %0d pulses expected 1 at tick %0d", stq.size(), t0 + 8); end
    btn[0] = 1'b0;
    run(7);
    checks++; if (lvl[0] !== 1'b1 || relq.size() != 0) begin errors++; $display("FAIL rel_early: lvl0=%0b rel=%0d expected 1 0", lvl[0], relq.size()); end
    run(1);
    checks++; if (rel_s[0] !== 1'b1 || lvl[0] !== 1'b0 || st_s[0] !== 1'b0) begin errors++; $display("FAIL rel_strobe: rel0=%0b lvl0=%0b st0=%0b expected 1 0 0", rel_s[0], lvl[0], st_s[0]); end
  endtask

  task automatic test_bounce();
    int t0;
    clr(0);
    btn[0] = 1'b1;
    run(3);
    btn[0] = 1'b0;
    run(1);
    btn[0] = 1'b1;
    t0 = tn;
    run(10);
    checks++; if (stq.size() != 1 || stq[0] != t0 + 8) begin errors++; $display("FAIL bounce_press: %0d pulses first at %0d expected 1 at %0d", stq.size(), stq.size() ? stq[0] : -1, t0 + 8); end
    btn[0] = 1'b0;
    run(8);
    checks++; if (lvl[0] !== 1'b0 || relq.size() != 1) begin errors++; $display("FAIL bounce_rel: lvl0=%0b rel=%0d expected 0 1", lvl[0], relq.size()); end
  endtask

  task automatic test_repeat();
    int tp;
    int exp_t[6] = '{0, 500, 600, 700, 800, 900};
    clr(0);
    rpt_en[0] = 1'b1;
    btn[0] = 1'b1;
    run(8);
    tp = tn;
    run(499);
    checks++; if (long[0] !== 1'b0) begin errors++; $display("FAIL rpt_long_early: got %0b expected 0", long[0]); end
    run(1);
    checks++; if (long[0] !== 1'b1 || st_s[0] !== 1'b1) begin errors++; $display("FAIL rpt_first: long0=%0b st0=%0b expected 1 1", long[0], st_s[0]); end
    run(490);
    checks++; if (long[0] !== 1'b1) begin errors++; $display("FAIL rpt_long_hold: got %0b expected 1", long[0]); end
    checks++; if (stq.size() != 6) begin errors++; $display("FAIL rpt_count: got %0d expected 6", stq.size()); end
    for (int k = 0; k < 6 && k < stq.size(); k++) begin
      checks++; if (stq[k] != tp + exp_t[k]) begin errors++; $display("FAIL rpt_time%0d: got +%0d expected +%0d", k, stq[k] - tp, exp_t[k]); end
    end
    btn[0] = 1'b0;
    run(8);
    checks++; if (rel_s[0] !== 1'b1 || long[0] !== 1'b0 || stq.size() != 6) begin errors++; $display("FAIL rpt_release: rel0=%0b long0=%0b pulses=%0d expected 1 0 6", rel_s[0], long[0], stq.size()); end
    rpt_en[0] = 1'b0;
  endtask

  task automatic test_no_repeat();
    int tq;
    clr(0);
    btn[0] = 1'b1;
    run(8);
    run(499);
    checks++; if (long[0] !== 1'b0) begin errors++; $display("FAIL norpt_long_early: got %0b expected 0", long[0]); end
    run(1);
    checks++; if (long[0] !== 1'b1 || st_s[0] !== 1'b0) begin errors++; $display("FAIL norpt_long: long0=%0b st0=%0b expected 1 0", long[0], st_s[0]); end
    run(300);
    checks++; if (stq.size() != 1) begin errors++; $display("FAIL norpt_pulses: got %0d expected 1", stq.size()); end
    rpt_en[0] = 1'b1;
    run(1);
    checks++; if (st_s[0] !== 1'b0) begin errors++; $display("FAIL late_en_nopulse: st0 got %0b expected 0", st_s[0]); end
    run(99);
    checks++; if (stq.size() != 1) begin errors++; $display("FAIL late_en_early: pulses got %0d expected 1", stq.size()); end
    run(1);
    tq = tn;
    checks++; if (st_s[0] !== 1'b1 || stq.size() != 2) begin errors++; $display("FAIL late_en_pulse: st0=%0b pulses=%0d expected 1 2", st_s[0], stq.size()); end
    rpt_en[0] = 1'b0;
    run(100);
    checks++; if (stq.size() != 2) begin errors++; $display("FAIL rpt_suppress: pulses got %0d expected 2", stq.size()); end
    rpt_en[0] = 1'b1;
    run(100);
    checks++; if (stq.size() != 3 || stq[stq.size() - 1] != tq + 200) begin errors++; $display("FAIL rpt_resume: pulses=%0d last=%0d expected 3 at %0d", stq.size(), stq[stq.size() - 1], tq + 200); end
    rpt_en[0] = 1'b0;
    btn[0] = 1'b0;
    run(8);
    checks++; if (rel_s[0] !== 1'b1 || long[0] !== 1'b0) begin errors++; $display("FAIL norpt_release: rel0=%0b long0=%0b expected 1 0", rel_s[0], long[0]); end
  endtask

  task automatic test_release_race();
    clr(0);
    rpt_en[0] = 1'b1;
    btn[0] = 1'b1;
    run(8);
    run(492);
    btn[0] = 1'b0;
    run(8);
    checks++; if (rel_s[0] !== 1'b1 || st_s[0] !== 1'b0) begin errors++; $display("FAIL race_strobes: rel0=%0b st0=%0b expected 1 0", rel_s[0], st_s[0]); end
    checks++; if (long[0] !== 1'b0 || stq.size() != 1) begin errors++; $display("FAIL race_long: long0=%0b pulses=%0d expected 0 1", long[0], stq.size()); end
    rpt_en[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    clr(1);
    btn = 4'hF;
    run(8);
    checks++; if (st_s !== 4'hF || lvl !== 4'hF) begin errors++; $display("FAIL multi_press: st=%0h lvl=%0h expected f f", st_s, lvl); end
    btn = 4'hA;
    run(8);
    checks++; if (rel_s !== 4'h5 || st_s !== 4'h0 || lvl !== 4'hA) begin errors++; $display("FAIL multi_partial: rel=%0h st=%0h lvl=%0h expected 5 0 a", rel_s, st_s, lvl); end
    btn = 4'h0;
    run(8);
    checks++; if (rel_s !== 4'hA || lvl !== 4'h0) begin errors++; $display("FAIL multi_release: rel=%0h lvl=%0h expected a 0", rel_s, lvl); end
  endtask

  task automatic test_reset_mid();
    clr(2);
    rpt_en = 4'b0100;
    btn = 4'b0101;
    run(8);
    run(550);
    checks++; if (long !== 4'b0101 || stq.size() != 2) begin errors++; $display("FAIL mid_pre: long=%0h pulses=%0d expected 5 2", long, stq.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ((st | rel | lvl | long) !== '0) begin errors++; $display("FAIL mid_reset: st=%0h rel=%0h lvl=%0h long=%0h expected 0", st, rel, lvl, long); end
    clr(2);
    run(7);
    checks++; if (lvl !== 4'b0000 || stq.size() != 0) begin errors++; $display("FAIL mid_early: lvl=%0h pulses=%0d expected 0 0", lvl, stq.size()); end
    run(1);
    checks++; if (st_s !== 4'b0101 || lvl !== 4'b0101 || relq.size() != 0) begin errors++; $display("FAIL mid_repress: st=%0h lvl=%0h rel=%0d expected 5 5 0", st_s, lvl, relq.size()); end
    btn = '0;
    rpt_en = '0;
    run(8);
    checks++; if (rel_s !== 4'b0101) begin errors++; $display("FAIL mid_release: rel=%0h expected 5", rel_s); end
  endtask

  task automatic test_strobe_rules();
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL strobe_no_ce: got %0d strobes expected 0", idle_bad); end
    checks++; if (both_bad != 0) begin errors++; $display("FAIL strobe_both: got %0d overlaps expected 0", both_bad); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_release_race();
    test_back_to_back();
    test_reset_mid();
    test_strobe_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
